// File: rtl/sbox_sched.sv
// Time-shares one registered 8-bit s-box between SubBytes (16 bytes) and SubWord (4 bytes).
// Bytes are issued one per cycle, captured SBOX_LAT cycles later and returned over valid/ready.
module sbox_sched #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_resp_valid,
  input  logic         st_resp_ready,
  output logic [127:0] st_resp_data,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_req_data,
  output logic         kw_resp_valid,
  input  logic         kw_resp_ready,
  output logic [31:0]  kw_resp_data,
  output logic [7:0]   sbox_in,
  input  logic [7:0]   sbox_out,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_ST = 1'b0;
  localparam logic OWN_KW = 1'b1;

  logic [1:0]          state_q, state_d;
  logic                owner_q;
  logic                last_grant_q;
  logic [127:0]        data_q;
  logic [3:0]          issue_cnt_q;
  logic [3:0]          cap_cnt_q;
  logic [SBOX_LAT-1:0] cap_pipe_q;
  logic [127:0]        st_res_q;
  logic [31:0]         kw_res_q;

  logic grant_st, grant_kw, st_hs, kw_hs, issuing, capture, resp_hs;
  logic [3:0] last_idx;

  // Round-robin: on a tie the requester that did not win last time goes first.
  assign grant_st = st_req_valid && (!kw_req_valid || last_grant_q == OWN_KW);
  assign grant_kw = kw_req_valid && !grant_st;

  assign st_req_ready = (state_q == IDLE) && grant_st;
  assign kw_req_ready = (state_q == IDLE) && grant_kw;
  assign st_hs        = st_req_valid && st_req_ready;
  assign kw_hs        = kw_req_valid && kw_req_ready;

  assign last_idx = (owner_q == OWN_ST) ? 4'd15 : 4'd3;
  assign issuing  = (state_q == ISSUE);
  assign capture  = cap_pipe_q[SBOX_LAT-1];

  assign sbox_in = issuing ? data_q[{issue_cnt_q, 3'b000} +: 8] : 8'h00;

  assign st_resp_valid = (state_q == RESP) && (owner_q == OWN_ST);
  assign kw_resp_valid = (state_q == RESP) && (owner_q == OWN_KW);
  assign st_resp_data  = st_res_q;
  assign kw_resp_data  = kw_res_q;
  assign busy          = (state_q != IDLE);

  assign resp_hs = (st_resp_valid && st_resp_ready) || (kw_resp_valid && kw_resp_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (st_hs || kw_hs) state_d = ISSUE;
      ISSUE:   if (issue_cnt_q == last_idx) state_d = DRAIN;
      DRAIN:   if (capture && cap_cnt_q == last_idx) state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_ST;
      last_grant_q <= OWN_KW;
      data_q       <= '0;
      issue_cnt_q  <= '0;
      cap_cnt_q    <= '0;
      cap_pipe_q   <= '0;
      st_res_q     <= '0;
      kw_res_q     <= '0;
    end else begin
      state_q <= state_d;
      if (st_hs) begin
        owner_q      <= OWN_ST;
        last_grant_q <= OWN_ST;
        data_q       <= st_req_data;
      end else if (kw_hs) begin
        owner_q      <= OWN_KW;
        last_grant_q <= OWN_KW;
        data_q       <= {96'h0, kw_req_data};
      end
      if (st_hs || kw_hs) begin
        issue_cnt_q <= '0;
        cap_cnt_q   <= '0;
      end
      if (issuing) issue_cnt_q <= issue_cnt_q + 4'd1;
      // The pipe tracks which issue slots have a result arriving; it lines up with sbox_out.
      cap_pipe_q[0] <= issuing;
      for (int i = 1; i < SBOX_LAT; i++) cap_pipe_q[i] <= cap_pipe_q[i-1];
      if (capture) begin
        cap_cnt_q <= cap_cnt_q + 4'd1;
        if (owner_q == OWN_ST) st_res_q[{cap_cnt_q, 3'b000} +: 8] <= sbox_out;
        else kw_res_q[{cap_cnt_q[1:0], 3'b000} +: 8] <= sbox_out;
      end
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: one instance at SBOX_LAT=1 and one at SBOX_LAT=3,
// each fed by a behavioural AES s-box pipeline of matching depth.
module tb_sbox_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tbl [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // SBOX_LAT = 1 instance
  logic         st_req_valid = 0, st_resp_ready = 0, kw_req_valid = 0, kw_resp_ready = 0;
  logic [127:0] st_req_data = '0;
  logic [31:0]  kw_req_data = '0;
  logic         st_req_ready, st_resp_valid, kw_req_ready, kw_resp_valid, busy;
  logic [127:0] st_resp_data;
  logic [31:0]  kw_resp_data;
  logic [7:0]   sbox_in, sbox_out;

  sbox_sched #(.SBOX_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_data(st_req_data),
    .st_resp_valid(st_resp_valid), .st_resp_ready(st_resp_ready), .st_resp_data(st_resp_data),
    .kw_req_valid(kw_req_valid), .kw_req_ready(kw_req_ready), .kw_req_data(kw_req_data),
    .kw_resp_valid(kw_resp_valid), .kw_resp_ready(kw_resp_ready), .kw_resp_data(kw_resp_data),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
  );

  always @(posedge clk) sbox_out <= sbox_tbl[sbox_in];

  // SBOX_LAT = 3 instance, only its KW side is exercised
  logic         d3_st_req_valid = 0, d3_st_resp_ready = 1, d3_kw_req_valid = 0, d3_kw_resp_ready = 0;
  logic [127:0] d3_st_req_data = '0;
  logic [31:0]  d3_kw_req_data = '0;
  logic         d3_st_req_ready, d3_st_resp_valid, d3_kw_req_ready, d3_kw_resp_valid, d3_busy;
  logic [127:0] d3_st_resp_data;
  logic [31:0]  d3_kw_resp_data;
  logic [7:0]   d3_sbox_in, d3_sbox_out, d3_s0, d3_s1;

  sbox_sched #(.SBOX_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(d3_st_req_valid), .st_req_ready(d3_st_req_ready), .st_req_data(d3_st_req_data),
    .st_resp_valid(d3_st_resp_valid), .st_resp_ready(d3_st_resp_ready), .st_resp_data(d3_st_resp_data),
    .kw_req_valid(d3_kw_req_valid), .kw_req_ready(d3_kw_req_ready), .kw_req_data(d3_kw_req_data),
    .kw_resp_valid(d3_kw_resp_valid), .kw_resp_ready(d3_kw_resp_ready), .kw_resp_data(d3_kw_resp_data),
    .sbox_in(d3_sbox_in), .sbox_out(d3_sbox_out), .busy(d3_busy)
  );

  always @(posedge clk) begin
    d3_s0       <= sbox_tbl[d3_sbox_in];
    d3_s1       <= d3_s0;
    d3_sbox_out <= d3_s1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Returns the cycle at which the selected resp_valid is first seen (-1 on timeout),
  // leaving the caller at the negedge of that cycle.
  task automatic wait_resp(input int which, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((which == 0 && st_resp_valid) || (which == 1 && kw_resp_valid) ||
          (which == 2 && d3_kw_resp_valid)) begin
        at = cyc;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({st_req_ready, kw_req_ready, st_resp_valid, kw_resp_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {st_req_ready, kw_req_ready, st_resp_valid, kw_resp_valid, busy});
    end
    checks++;
    if ({st_resp_data, kw_resp_data, sbox_in} !== '0) begin
      errors++;
      $display("FAIL reset_data: got st=%h kw=%h sbox_in=%h expected all zero",
               st_resp_data, kw_resp_data, sbox_in);
    end
    $display("test_reset done");
  endtask

  task automatic test_st_zero;
    int t, at;
    tick();
    st_req_valid = 1; st_req_data = '0; st_resp_ready = 1;
    @(negedge clk);
    t = cyc;
    checks++;
    if (st_req_ready !== 1'b1) begin
      errors++; $display("FAIL st_zero_ready: got %b expected 1", st_req_ready);
    end
    tick();
    st_req_valid = 0;
    wait_resp(0, at);
    checks++;
    if (at != t + 18) begin
      errors++; $display("FAIL st_zero_latency: got cycle %0d expected %0d", at, t + 18);
    end
    checks++;
    if (st_resp_data !== {16{8'h63}}) begin
      errors++; $display("FAIL st_zero_data: got %h expected %h", st_resp_data, {16{8'h63}});
    end
    checks++;
    if (kw_resp_valid !== 1'b0) begin
      errors++; $display("FAIL st_zero_kw_valid: got %b expected 0", kw_resp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({st_resp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL st_zero_idle: got valid,busy=%b expected 00", {st_resp_valid, busy});
    end
    st_resp_ready = 0;
    $display("test_st_zero done: st_resp_data=%h", st_resp_data);
  endtask

  task automatic test_kw_vector;
    int t, at;
    logic [7:0] exp_in [4] = '{8'hFF, 8'h53, 8'h01, 8'h00};
    tick();
    kw_req_valid = 1; kw_req_data = 32'h0001_53FF; kw_resp_ready = 1;
    @(negedge clk);
    t = cyc;
    checks++;
    if (kw_req_ready !== 1'b1) begin
      errors++; $display("FAIL kw_ready: got %b expected 1", kw_req_ready);
    end
    tick();
    kw_req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (sbox_in !== exp_in[k]) begin
        errors++; $display("FAIL kw_sbox_in[%0d]: got %h expected %h", k, sbox_in, exp_in[k]);
      end
      tick();
    end
    wait_resp(1, at);
    checks++;
    if (at != t + 6) begin
      errors++; $display("FAIL kw_latency: got cycle %0d expected %0d", at, t + 6);
    end
    checks++;
    if (kw_resp_data !== 32'h637C_ED16) begin
      errors++; $display("FAIL kw_data: got %h expected 637ced16", kw_resp_data);
    end
    tick();
    kw_resp_ready = 0;
    $display("test_kw_vector done: kw_resp_data=%h", kw_resp_data);
  endtask

  task automatic test_tie_hold;
    int t, at;
    logic [127:0] exp_st = 128'h76abd7fe2b670130c56f6bf27b777c63;
    apply_reset();
    st_req_valid = 1; st_req_data = 128'h0f0e0d0c0b0a09080706050403020100;
    kw_req_valid = 1; kw_req_data = 32'h0102_0304;
    st_resp_ready = 0; kw_resp_ready = 1;
    @(negedge clk);
    checks++;
    if ({st_req_ready, kw_req_ready} !== 2'b10) begin
      errors++; $display("FAIL tie_first_grant: got st,kw=%b expected 10", {st_req_ready, kw_req_ready});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({st_req_ready, kw_req_ready, busy} !== 3'b001) begin
      errors++; $display("FAIL tie_busy_backpressure: got %b expected 001", {st_req_ready, kw_req_ready, busy});
    end
    wait_resp(0, at);
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({st_resp_valid, busy, st_req_ready, kw_req_ready} !== 4'b1100 || st_resp_data !== exp_st) begin
        errors++;
        $display("FAIL hold[%0d]: got valid,busy,rdy=%b data=%h expected 1100 data=%h",
                 i, {st_resp_valid, busy, st_req_ready, kw_req_ready}, st_resp_data, exp_st);
      end
    end
    st_resp_ready = 1;
    tick();
    st_resp_ready = 0;
    @(negedge clk);
    t = cyc;
    checks++;
    if ({st_resp_valid, busy, st_req_ready, kw_req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL tie_second_grant: got valid,busy,st_rdy,kw_rdy=%b expected 0001",
               {st_resp_valid, busy, st_req_ready, kw_req_ready});
    end
    tick();
    st_req_valid = 0; kw_req_valid = 0;
    wait_resp(1, at);
    checks++;
    if (at != t + 6 || kw_resp_data !== 32'h7C77_7BF2) begin
      errors++; $display("FAIL tie_kw_result: got cycle %0d data %h expected cycle %0d data 7c777bf2",
                         at, kw_resp_data, t + 6);
    end
    checks++;
    if (st_resp_data !== exp_st || st_resp_valid !== 1'b0) begin
      errors++; $display("FAIL st_retain: got %h valid %b expected %h valid 0",
                         st_resp_data, st_resp_valid, exp_st);
    end
    tick();
    kw_resp_ready = 0;
    $display("test_tie_hold done");
  endtask

  task automatic test_reset_mid;
    int at;
    logic seen;
    tick();
    st_req_valid = 1; st_req_data = {16{8'hA5}}; st_resp_ready = 1;
    @(negedge clk);
    checks++;
    if (st_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b expected 1", st_req_ready);
    end
    tick();
    st_req_valid = 0;
    repeat (7) tick();
    rst_n = 0;
    #1;
    checks++;
    if ({st_req_ready, kw_req_ready, st_resp_valid, kw_resp_valid, busy} !== 5'b0 ||
        {st_resp_data, kw_resp_data, sbox_in} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got flags=%b st=%h kw=%h sbox_in=%h expected all zero",
               {st_req_ready, kw_req_ready, st_resp_valid, kw_resp_valid, busy},
               st_resp_data, kw_resp_data, sbox_in);
    end
    tick(); tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (st_resp_valid) seen = 1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL mid_no_resp: got st_resp_valid seen=%b expected 0", seen);
    end
    st_resp_ready = 0;
    kw_req_valid = 1; kw_req_data = 32'h0001_53FF; kw_resp_ready = 1;
    @(negedge clk);
    tick();
    kw_req_valid = 0;
    wait_resp(1, at);
    checks++;
    if (at < 0 || kw_resp_data !== 32'h637C_ED16) begin
      errors++; $display("FAIL mid_fresh_kw: got cycle %0d data %h expected data 637ced16", at, kw_resp_data);
    end
    tick();
    kw_resp_ready = 0;
    $display("test_reset_mid done");
  endtask

  task automatic test_lat3;
    int t, at;
    tick();
    d3_kw_req_valid = 1; d3_kw_req_data = 32'h0102_0304; d3_kw_resp_ready = 1;
    @(negedge clk);
    t = cyc;
    checks++;
    if (d3_kw_req_ready !== 1'b1) begin
      errors++; $display("FAIL lat3_ready: got %b expected 1", d3_kw_req_ready);
    end
    tick();
    d3_kw_req_valid = 0;
    wait_resp(2, at);
    checks++;
    if (at != t + 8) begin
      errors++; $display("FAIL lat3_latency: got cycle %0d expected %0d", at, t + 8);
    end
    checks++;
    if (d3_kw_resp_data !== 32'h7C77_7BF2) begin
      errors++; $display("FAIL lat3_data: got %h expected 7c777bf2", d3_kw_resp_data);
    end
    tick();
    $display("test_lat3 done: kw_resp_data=%h", d3_kw_resp_data);
  endtask

  initial begin
    test_reset();
    test_st_zero();
    test_kw_vector();
    test_tie_hold();
    test_reset_mid();
    test_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Shares a single registered s-box lookup (8-bit in, 8-bit out, fixed latency) between two requesters.
  - The round datapath (ST) issues 16-byte SubBytes on a 128-bit state.
  - The key expander (KW) issues 4-byte SubWord on a 32-bit word.
- Serialises each request into one byte per cycle into the s-box, reassembles the results and returns them over a valid/ready response channel.
- Sits between the AES round controller / key schedule and the s-box instance.
- Only one transaction is in flight at a time.

Parameters:
- SBOX_LAT, 1, cycles from driving sbox_in to the matching sbox_out being valid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_req_valid  in  1  SubBytes request valid
- st_req_ready  out  1  SubBytes request accepted when valid&&ready
- st_req_data  in  128  state; byte i = bits [8i+7:8i]
- st_resp_valid  out  1  SubBytes result valid
- st_resp_ready  in  1  SubBytes result consumed when valid&&ready
- st_resp_data  out  128  substituted state; byte i = S(input byte i)
- kw_req_valid  in  1  SubWord request valid
- kw_req_ready  out  1  SubWord request accept
- kw_req_data  in  32  word; byte i = bits [8i+7:8i]
- kw_resp_valid  out  1  SubWord result valid
- kw_resp_ready  in  1  SubWord result consumed
- kw_resp_data  out  32  substituted word
- sbox_in  out  8  byte presented to the s-box
- sbox_out  in  8  s-box result, SBOX_LAT cycles after sbox_in
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous) clears the following:
  - State goes to IDLE.
  - All *_ready, *_resp_valid and busy outputs are 0.
  - *_resp_data are all-zero.
  - sbox_in is 0.
  - Issue and capture counters are 0.
  - last_grant is set to KW.
- Reset mid-transaction discards the transaction; no response is produced afterwards.
- States: IDLE -> ISSUE -> DRAIN -> RESP -> IDLE.
- IDLE, arbitration:
  - If exactly one request is valid, grant it.
  - If both are valid, grant the requester that is not last_grant (round-robin).
  - Only the granted requester's req_ready is high; it is combinational from the valids, in IDLE only.
  - On handshake: latch the data, record the owner and size N (16 for ST, 4 for KW), set last_grant to the owner, go to ISSUE.
- ISSUE:
  - Runs for N cycles; in cycle k (k = 0..N-1) sbox_in = latched byte k.
  - Outside ISSUE, sbox_in = 0.
- Capture: sbox_out at edge (issue cycle of byte k) + SBOX_LAT is written into result byte k.
- DRAIN:
  - Entered after the last issue cycle.
  - Lasts SBOX_LAT cycles, until byte N-1 is captured; then go to RESP.
- Latency: if the request handshake is in cycle T, the owner's resp_valid is first high in cycle T+N+SBOX_LAT+1.
  - ST: T+18 at SBOX_LAT=1.
  - KW: T+6 at SBOX_LAT=1.
- RESP:
  - The owner's resp_valid is held high, with resp_data stable, until its resp_ready.
  - On that handshake: resp_valid falls the next cycle and the state returns to IDLE.
  - The earliest new request accept is the cycle after the response handshake.
  - The non-owner's resp_valid stays 0.
- resp_data retains the last result after the handshake, until overwritten by the next capture for that owner.
- Both req_ready are 0 in every state other than IDLE, so backpressure applies to new requests while busy.
- A request valid that drops before handshake has no effect; no state change.
- Byte positions are preserved: result byte i corresponds to input byte i.

Test Plan:
- Reset, then st_req_data = 128'h0 at T -> st_resp_valid at T+18, st_resp_data = 128'h6363…63 (16 bytes of 0x63); kw_resp_valid stays 0.
- kw_req_data = 32'h0001_53FF -> kw_resp_data = 32'h637C_ED16 at T+6; sbox_in sequence FF, 53, 01, 00 in 4 consecutive cycles starting T+1.
- Both valid in the same cycle after reset -> ST granted first (kw_req_ready = 0). KW is accepted the cycle after the ST response handshake. On the next tie, KW is still granted before ST.
- Hold st_resp_ready low for 5 cycles after st_resp_valid rises -> st_resp_data stable, busy = 1, both req_ready = 0; release -> IDLE next cycle.
- Assert rst_n low during the 8th ISSUE cycle of an ST request -> all outputs zero immediately; no st_resp_valid after release. A fresh KW request completes with correct data.
- SBOX_LAT = 3 with a modelled 3-stage s-box, KW request 32'h0102_0304 -> kw_resp_valid at T+8, kw_resp_data = 32'h7C77_7BF2.
